// File: rtl/fma_vector_checker_if.sv
// Bundle of load, control, status and DUT-facing signals for fma_vector_checker.
// Ports (by group):
//   load:    load_we, load_addr[AW], load_data[VW]
//   control: num_vectors[AW+1], start, check_flags, nan_any
//   DUT:     x, y, z[FW], roundmode[2], mul, add, negp, negz (to DUT);
//            dut_result[FW], dut_flags[FLAGW] (from DUT)
//   status:  busy, done, err_pulse, errors[32], vec_count[AW+1],
//            first_err_valid, first_err_idx[AW]
// master = the checker, slave = the environment (loader, DUT, monitor).
interface fma_vector_checker_if #(
  parameter int unsigned FW    = 16,
  parameter int unsigned FLAGW = 4,
  parameter int unsigned AW    = 10
);
  localparam int unsigned VW = 4 * FW + 8 + FLAGW;

  logic             load_we;
  logic [AW-1:0]    load_addr;
  logic [VW-1:0]    load_data;
  logic [AW:0]      num_vectors;
  logic             start;
  logic             check_flags;
  logic             nan_any;
  logic [FW-1:0]    x;
  logic [FW-1:0]    y;
  logic [FW-1:0]    z;
  logic [1:0]       roundmode;
  logic             mul;
  logic             add;
  logic             negp;
  logic             negz;
  logic [FW-1:0]    dut_result;
  logic [FLAGW-1:0] dut_flags;
  logic             busy;
  logic             done;
  logic             err_pulse;
  logic [31:0]      errors;
  logic [AW:0]      vec_count;
  logic             first_err_valid;
  logic [AW-1:0]    first_err_idx;

  modport master (
    input  load_we, load_addr, load_data, num_vectors, start, check_flags, nan_any,
    input  dut_result, dut_flags,
    output x, y, z, roundmode, mul, add, negp, negz,
    output busy, done, err_pulse, errors, vec_count, first_err_valid, first_err_idx
  );

  modport slave (
    output load_we, load_addr, load_data, num_vectors, start, check_flags, nan_any,
    output dut_result, dut_flags,
    input  x, y, z, roundmode, mul, add, negp, negz,
    input  busy, done, err_pulse, errors, vec_count, first_err_valid, first_err_idx
  );
endinterface

// File: rtl/fma_vector_checker.sv
// Vector sequencer/checker for FMA datapaths.
// Streams vectors from an internal memory into a DUT (one per cycle), delays the
// expected result/flags by LAT cycles to line up with the DUT and compares them.
// Ports:
//   clk    clock
//   reset  synchronous, active-low
//   bus    fma_vector_checker_if.master (load port, control, DUT operands and
//          result, status counters)
// Vector word, MSB->LSB: x, y, z, ctrl[7:0], rexp, fexp.
// err_pulse is combinational: it flags the compare happening in the same cycle.
module fma_vector_checker #(
  parameter int unsigned FW    = 16,
  parameter int unsigned EW    = 5,
  parameter int unsigned FLAGW = 4,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 0
) (
  input logic                   clk,
  input logic                   reset,
  fma_vector_checker_if.master  bus
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MW       = FW - 1 - EW;
  localparam int unsigned VW       = 4 * FW + 8 + FLAGW;
  localparam int unsigned REXP_LSB = FLAGW;
  localparam int unsigned CTRL_LSB = FLAGW + FW;
  localparam int unsigned Z_LSB    = CTRL_LSB + 8;
  localparam int unsigned Y_LSB    = Z_LSB + FW;
  localparam int unsigned X_LSB    = Y_LSB + FW;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             valid;
    logic             last;
    logic [AW-1:0]    idx;
    logic [FW-1:0]    rexp;
    logic [FLAGW-1:0] fexp;
  } exp_t;

  state_t        state_q, state_d;
  logic [VW-1:0] mem [DEPTH];
  logic [VW-1:0] rd_q;
  logic [AW-1:0] rd_addr_q;
  logic [AW:0]   n_q;
  logic          chk_q, nan_q;
  logic          s0_valid_q, s0_last_q;
  logic [AW-1:0] s0_idx_q;
  logic          start_acc_c, rd_en_c, issue_last_c, busy_c;
  logic          res_match_c, flag_match_c, mismatch_c;
  exp_t          st0_c, cmp_c;

  function automatic logic is_nan(input logic [FW-1:0] v);
    return (&v[FW-2 -: EW]) && (|v[MW-1:0]);
  endfunction

  assign busy_c       = (state_q == RUN) || (state_q == DRAIN);
  assign start_acc_c  = bus.start && !busy_c;
  assign issue_last_c = ({1'b0, rd_addr_q} == (n_q - CNT_ONE));

  // State register plus registered busy/done
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus.busy <= (state_d == RUN) || (state_d == DRAIN);
      bus.done <= (state_d == DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    rd_en_c = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) state_d = (bus.num_vectors == '0) ? DONE : RUN;
      end
      RUN: begin
        rd_en_c = 1'b1;
        if (issue_last_c) state_d = DRAIN;
      end
      DRAIN: begin
        if (cmp_c.valid && cmp_c.last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Vector memory write port; loads are dropped while a run is in flight
  always_ff @(posedge clk) begin
    if (bus.load_we && !busy_c) mem[bus.load_addr] <= bus.load_data;
  end

  // Run configuration, read address and registered read data (stage 0)
  always_ff @(posedge clk) begin
    if (!reset) begin
      n_q        <= '0;
      chk_q      <= 1'b0;
      nan_q      <= 1'b0;
      rd_addr_q  <= '0;
      rd_q       <= '0;
      s0_valid_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_idx_q   <= '0;
    end else begin
      if (start_acc_c) begin
        n_q       <= bus.num_vectors;
        chk_q     <= bus.check_flags;
        nan_q     <= bus.nan_any;
        rd_addr_q <= '0;
      end
      if (rd_en_c) begin
        rd_q      <= mem[rd_addr_q];
        rd_addr_q <= rd_addr_q + AW'(1);
      end
      s0_valid_q <= rd_en_c;
      s0_last_q  <= rd_en_c && issue_last_c;
      s0_idx_q   <= rd_addr_q;
    end
  end

  // Operands come straight from the read-data register
  assign bus.x         = rd_q[X_LSB +: FW];
  assign bus.y         = rd_q[Y_LSB +: FW];
  assign bus.z         = rd_q[Z_LSB +: FW];
  assign bus.roundmode = rd_q[CTRL_LSB+4 +: 2];
  assign bus.mul       = rd_q[CTRL_LSB+3];
  assign bus.add       = rd_q[CTRL_LSB+2];
  assign bus.negp      = rd_q[CTRL_LSB+1];
  assign bus.negz      = rd_q[CTRL_LSB];

  always_comb begin
    st0_c       = '0;
    st0_c.valid = s0_valid_q;
    st0_c.last  = s0_last_q;
    st0_c.idx   = s0_idx_q;
    st0_c.rexp  = rd_q[REXP_LSB +: FW];
    st0_c.fexp  = rd_q[FLAGW-1:0];
  end

  // Expected-value delay line matching the DUT latency
  if (LAT == 0) begin : g_lat0
    assign cmp_c = st0_c;
  end else begin : g_pipe
    exp_t pipe_q [LAT];
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
      end else begin
        pipe_q[0] <= st0_c;
        for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
      end
    end
    assign cmp_c = pipe_q[LAT-1];
  end

  // Compare: exact match, or NaN-vs-NaN when nan_any was latched
  assign res_match_c  = (bus.dut_result == cmp_c.rexp) ||
                        (nan_q && is_nan(bus.dut_result) && is_nan(cmp_c.rexp));
  assign flag_match_c = !chk_q || (bus.dut_flags == cmp_c.fexp);
  assign mismatch_c   = cmp_c.valid && !(res_match_c && flag_match_c);
  assign bus.err_pulse = mismatch_c;

  // Run statistics
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.errors          <= '0;
      bus.vec_count       <= '0;
      bus.first_err_valid <= 1'b0;
      bus.first_err_idx   <= '0;
    end else if (start_acc_c) begin
      bus.errors          <= '0;
      bus.vec_count       <= '0;
      bus.first_err_valid <= 1'b0;
      bus.first_err_idx   <= '0;
    end else if (cmp_c.valid) begin
      bus.vec_count <= bus.vec_count + CNT_ONE;
      if (mismatch_c) begin
        if (bus.errors != '1) bus.errors <= bus.errors + 32'd1;
        if (!bus.first_err_valid) begin
          bus.first_err_valid <= 1'b1;
          bus.first_err_idx   <= cmp_c.idx;
        end
      end
    end
  end

endmodule

// File: doc/fma_vector_checker.md
Name: fma_vector_checker

Overview:
- Synthesizable, parametrised vector sequencer and checker for FMA datapaths (fma16 and wider successors).
- Holds a test-vector memory that is loaded through a write port. Streams one vector per cycle into a DUT whose pipeline latency is configurable.
- Compares the DUT result and flags against expected values, with optional flag checking and NaN-tolerant comparison.
- Reports error count, vector count and the first failing index. Used in on-FPGA regression and in self-checking simulation harnesses.

Parameters:
- FW, 16, floating-point format width (16 half, 32 single)
- EW, 5, exponent width (8 when FW=32); mantissa width MW = FW-1-EW
- FLAGW, 4, flag width {invalid, overflow, underflow, inexact}
- DEPTH, 1024, vector memory entries; AW = $clog2(DEPTH)
- LAT, 0, DUT latency in cycles (0 = combinational DUT)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- load_we  in  1  vector memory write enable
- load_addr  in  AW  write address
- load_data  in  VW  vector word, VW = 4*FW+8+FLAGW; fields MSB->LSB: x, y, z, ctrl[7:0], rexp, fexp
- num_vectors  in  AW+1  number of vectors to run (0..DEPTH)
- start  in  1  run request (pulse)
- check_flags  in  1  compare flags too; latched at start
- nan_any  in  1  any NaN result matches a NaN expectation; latched at start
- x, y, z  out  FW each  DUT operands
- roundmode  out  2  ctrl[5:4]
- mul, add, negp, negz  out  1 each  ctrl[3], ctrl[2], ctrl[1], ctrl[0]; ctrl[7:6] ignored
- dut_result  in  FW  DUT result
- dut_flags  in  FLAGW  DUT flags
- busy  out  1  state is RUN or DRAIN
- done  out  1  run complete; level signal
- err_pulse  out  1  one-cycle strobe per mismatching vector
- errors  out  32  mismatch count, saturating
- vec_count  out  AW+1  vectors compared
- first_err_valid  out  1  at least one mismatch this run
- first_err_idx  out  AW  index of first mismatch

Behaviour:
- Reset (reset==0 at posedge):
  - state IDLE; all outputs 0, including operands and ctrl outputs.
  - Pipelines and counters cleared; memory contents undefined/retained.
- Memory: 1 write port; 1 read port with registered read data. load_we is ignored while busy.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - latch num_vectors, check_flags, nan_any;
  - clear errors, vec_count, first_err_*; drop done;
  - go to RUN, or directly to DONE if num_vectors==0 (done=1 the next cycle).
- start while busy: ignored.
- RUN:
  - read address i = 0..N-1 issued on consecutive cycles; after issuing N-1, go to DRAIN.
  - Start accepted at edge T: read i issued in cycle T+1+i; operands for vector i driven during cycle T+2+i.
- Expected values (rexp, fexp, index) travel through a LAT-stage shift pipeline aligned with the DUT. Vector i is compared during cycle T+2+i+LAT; the counters update at the end of that cycle.
- Match rule, per vector:
  - result match: dut_result == rexp, OR (nan_any AND both are NaN). NaN means exponent all ones and mantissa != 0.
  - flag match: !check_flags OR dut_flags == fexp.
  - mismatch = !(result match AND flag match).
- On each compare:
  - vec_count += 1.
  - On mismatch: errors += 1 (saturating at 2^32-1) and err_pulse=1 that cycle. If first_err_valid==0, capture the index and set first_err_valid.
- DRAIN: leave after the last compare; go to DONE. done=1 from cycle T+N+2+LAT and holds until the next accepted start or reset.
- Simultaneous start and final compare: start is ignored (state still busy).
- Reset mid-run: immediate abort to IDLE with all outputs zeroed. A subsequent start reruns from index 0.

Test Plan:
- FW=16, LAT=0, combinational reference FMA. Load 3 vectors incl. {3C00,3C00,0000,08,3C00,0}, start at T -> errors=0, vec_count=3, done rises at T+5, first_err_valid=0.
- Same 3 vectors with vector 1 rexp changed to 4000 (DUT gives 3C00) -> errors=1, first_err_idx=1, err_pulse high for exactly one cycle (T+3).
- Result matches, DUT flags 0001 vs fexp 0000:
  - check_flags=0 -> errors=0;
  - check_flags=1 -> errors=1.
  - check_flags toggled mid-run has no effect.
- Expected 7E00, DUT returns 7C01:
  - nan_any=1 -> pass;
  - nan_any=0 -> errors=1.
  - Expected 7C00 (infinity) vs 7C01 with nan_any=1 -> fail.
- Boundary conditions:
  - num_vectors=0 -> done=1 one cycle after start, errors=0.
  - Reset asserted during vector 2 of 5 -> next cycle all outputs 0, state IDLE; restart gives vec_count=5.
  - Start pulsed while busy -> no effect.
- LAT=3 with a 3-stage registered DUT model, N=4 -> identical counts; done at T+9; first_err_idx correct for an injected error at vector 3.
